key_debounce: RTL and testbench
===============================

# key_debounce

Multi-key debouncer that sits directly upstream of the edge detector. It takes raw, asynchronous, bouncing push-button inputs and synchronises each bit to `clk`. Each key's output level changes only after the input has been stable at a new value for a programmable number of cycles. The clean per-key level `key_value` feeds the edge detector's input; `key_flag` marks each accepted change for logic that does not need separate rising and falling edges.

## Interface
Parameters:
- `KEY_W`, 4: number of independent keys.
- `CNT_MAX`, 1000000: consecutive differing samples required to accept a change (20 ms at 50 MHz). Legal range is CNT_MAX ≥ 2.
- `KEY_INIT`, 1'b1: idle level of every key. Keys are active-low by default.

Ports:
- `clk`, input, 1: system clock. This is the only clock.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `key_in`, input, KEY_W: raw key pins. Asynchronous and bouncing.
- `key_value`, output, KEY_W: debounced level per key. Registered.
- `key_flag`, output, KEY_W: one-cycle pulse per key, high in the same cycle `key_value[i]` takes its new value. Registered.

## Operation
- Each bit passes through a 2-flop synchroniser (`sync1` → `sync2`). Both flops reset to `KEY_INIT`. Only `sync2` is used downstream.
- Each key `i` owns a counter `cnt[i]` of width `$clog2(CNT_MAX)`. Keys are fully independent.
- Each key has two implicit states:
  - **STABLE**: `sync2[i] == key_value[i]`. Action: `cnt[i] <= 0`.
  - **COUNT**: `sync2[i] != key_value[i]`.
    - If `cnt[i] < CNT_MAX-1`: `cnt[i] <= cnt[i]+1`.
    - If `cnt[i] == CNT_MAX-1`: `key_value[i] <= sync2[i]`, `key_flag[i] <= 1`, `cnt[i] <= 0`.
- Any sample during COUNT where `sync2[i]` matches `key_value[i]` again (a bounce) returns the key to STABLE and restarts the count from 0. Partial counts never accumulate across bounces.
- `key_flag[i]` is 0 in every cycle other than the accept cycle. Rising and falling changes are flagged identically.
- The counter never exceeds CNT_MAX-1 and never wraps.
- Reset behaviour, including reset mid-count:
  - `sync1`, `sync2` and `key_value` go to `KEY_INIT` on all bits.
  - `key_flag` goes to 0 and all `cnt` go to 0.
  - A change in progress is discarded.
- Reset has priority over any accept in the same cycle.

## Timing
- Reset values: `key_value = {KEY_W{KEY_INIT}}`, `key_flag = 0`.
- Latency: `key_in[i]` changes and stays stable before edge 0. Then:
  - `sync2` updates at edge 2.
  - The COUNT samples are edges 3 … CNT_MAX+2.
  - `key_value[i]` and `key_flag[i]` update at edge CNT_MAX+2, which is CNT_MAX+2 cycles of total latency.
- Minimum accepted pulse width is CNT_MAX cycles as seen at `sync2`. An input held for fewer cycles produces no output change.
- Several keys may accept in the same cycle. Each `key_flag` bit asserts independently.
- Throughput: after an accept, the opposite transition needs another full CNT_MAX stable samples.

## Test plan
All scenarios use CNT_MAX=8, KEY_W=4 and KEY_INIT=1.
- **Reset values**: assert `rst` for 3 cycles with `key_in=4'b0000` → `key_value=4'hF` and `key_flag=0` throughout and on the first cycle after release.
- **Clean press**: `key_in[0]` goes 1→0 before edge 0 and is held → `key_value[0]=0` with `key_flag=4'b0001` exactly at edge 10. The flag is 0 at edge 11 and no further change follows.
- **Bounce rejection**: `key_in[1]` low for 7 cycles, high for 1, low for 7, then high → `key_value[1]` stays 1 and `key_flag[1]` never asserts. Then hold low for 8+ cycles → accept 10 cycles after the final falling edge.
- **Simultaneous keys**: `key_in[2]` and `key_in[3]` drop in the same cycle → both bits of `key_value` fall and `key_flag=4'b1100` in a single cycle. Keys 0 and 1 are unaffected.
- **Release**: after a press on key 0, `key_in[0]` returns to 1 → `key_value[0]=1` with a `key_flag[0]` pulse 10 cycles later.
- **Reset mid-count**: `key_in[0]` low for 6 cycles, then `rst` for 1 cycle, with the input still low → no flag before reset. Counting restarts after reset, and the accept occurs 10 cycles after `rst` deasserts.

Source files
------------

// File: rtl/key_debounce.sv
// Multi-key push-button debouncer: 2-flop synchroniser per key, then a per-key
// stability counter that accepts a new level after CNT_MAX consecutive differing samples.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_STABLE | synchronised input equals key_value; counter held at 0
// ST_COUNT  | synchronised input differs; counting toward acceptance
module key_debounce #(
  parameter int unsigned KEY_W    = 4,
  parameter int unsigned CNT_MAX  = 1000000,
  parameter logic        KEY_INIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_value,
  output logic [KEY_W-1:0] key_flag
);

  localparam int unsigned     CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [KEY_W-1:0] IDLE    = {KEY_W{KEY_INIT}};

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } key_state_e;

  logic [KEY_W-1:0] sync1_q, sync1_d;
  logic [KEY_W-1:0] sync2_q, sync2_d;
  logic [KEY_W-1:0] key_value_q, key_value_d;
  logic [KEY_W-1:0] key_flag_q, key_flag_d;
  logic [CW-1:0]    cnt_q [KEY_W];
  logic [CW-1:0]    cnt_d [KEY_W];
  key_state_e       key_state [KEY_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= IDLE;
      sync2_q     <= IDLE;
      key_value_q <= IDLE;
      key_flag_q  <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_value_q <= key_value_d;
      key_flag_q  <= key_flag_d;
      for (int i = 0; i < KEY_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    key_value_d = key_value_q;
    key_flag_d  = '0;
    for (int i = 0; i < KEY_W; i++) begin
      cnt_d[i]     = '0;
      key_state[i] = (sync2_q[i] == key_value_q[i]) ? ST_STABLE : ST_COUNT;
      case (key_state[i])
        ST_STABLE: cnt_d[i] = '0;
        ST_COUNT: begin
          // A matching sample anywhere in the run drops back to ST_STABLE,
          // so only an unbroken run of CNT_MAX samples reaches the accept.
          if (cnt_q[i] == CNT_LAST) begin
            key_value_d[i] = sync2_q[i];
            key_flag_d[i]  = 1'b1;
            cnt_d[i]       = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  assign key_value = key_value_q;
  assign key_flag  = key_flag_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed, table-driven bench for key_debounce with CNT_MAX=8, KEY_W=4, KEY_INIT=1.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_value;
  logic [3:0] key_flag;

  int n_err;
  int n_checks;

  key_debounce #(
    .KEY_W   (4),
    .CNT_MAX (8),
    .KEY_INIT(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_value(key_value),
    .key_flag (key_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] key;
    logic [3:0] val;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic [3:0] k,
                     input logic [3:0] v, input logic [3:0] f);
    vec_t e;
    e.rst = r;
    e.key = k;
    e.val = v;
    e.flg = f;
    repeat (n) vecs.push_back(e);
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles until key_flag[b] is seen, or -1 if not within the budget.
  task automatic wait_flag(input int b, input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      if (key_flag[b] === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int first3;
    int first2;
    int both;
    n_err    = 0;
    n_checks = 0;
    rst      = 1'b1;
    key_in   = 4'b1111;

    // Inputs of entry k are applied just after an edge and sampled by the next
    // one, so an accept shows up on the 10th entry after the change.
    // reset, then first cycle after release
    add(3, 1'b1, 4'b0000, 4'hF, 4'h0);
    add(1, 1'b0, 4'b0000, 4'hF, 4'h0);
    add(4, 1'b0, 4'b1111, 4'hF, 4'h0);
    // clean press key 0
    add(9, 1'b0, 4'b1110, 4'hF, 4'h0);
    add(1, 1'b0, 4'b1110, 4'hE, 4'h1);
    add(3, 1'b0, 4'b1110, 4'hE, 4'h0);
    // release key 0
    add(9, 1'b0, 4'b1111, 4'hE, 4'h0);
    add(1, 1'b0, 4'b1111, 4'hF, 4'h1);
    add(2, 1'b0, 4'b1111, 4'hF, 4'h0);
    // bounce on key 1: 7 low, 1 high, 7 low, high, then a real press
    add(7, 1'b0, 4'b1101, 4'hF, 4'h0);
    add(1, 1'b0, 4'b1111, 4'hF, 4'h0);
    add(7, 1'b0, 4'b1101, 4'hF, 4'h0);
    add(3, 1'b0, 4'b1111, 4'hF, 4'h0);
    add(9, 1'b0, 4'b1101, 4'hF, 4'h0);
    add(1, 1'b0, 4'b1101, 4'hD, 4'h2);
    add(2, 1'b0, 4'b1101, 4'hD, 4'h0);
    add(9, 1'b0, 4'b1111, 4'hD, 4'h0);
    add(1, 1'b0, 4'b1111, 4'hF, 4'h2);
    add(2, 1'b0, 4'b1111, 4'hF, 4'h0);
    // keys 2 and 3 together, press and release
    add(9, 1'b0, 4'b0011, 4'hF, 4'h0);
    add(1, 1'b0, 4'b0011, 4'h3, 4'hC);
    add(2, 1'b0, 4'b0011, 4'h3, 4'h0);
    add(9, 1'b0, 4'b1111, 4'h3, 4'h0);
    add(1, 1'b0, 4'b1111, 4'hF, 4'hC);
    add(2, 1'b0, 4'b1111, 4'hF, 4'h0);
    // reset in the middle of a key 0 count
    add(6, 1'b0, 4'b1110, 4'hF, 4'h0);
    add(1, 1'b1, 4'b1110, 4'hF, 4'h0);
    add(9, 1'b0, 4'b1110, 4'hF, 4'h0);
    add(1, 1'b0, 4'b1110, 4'hE, 4'h1);
    add(2, 1'b0, 4'b1110, 4'hE, 4'h0);
    add(9, 1'b0, 4'b1111, 4'hE, 4'h0);
    add(1, 1'b0, 4'b1111, 4'hF, 4'h1);
    add(3, 1'b0, 4'b1111, 4'hF, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst    = vecs[i].rst;
      key_in = vecs[i].key;
      step();
      chk4($sformatf("vec%0d key_value", i), key_value, vecs[i].val);
      chk4($sformatf("vec%0d key_flag", i), key_flag, vecs[i].flg);
    end

    // Reset landing on the accept edge wins over the accept.
    key_in = 4'b1110;
    repeat (9) step();
    chk4("pre_accept key_value", key_value, 4'hF);
    rst = 1'b1;
    step();
    chk4("rst_vs_accept key_value", key_value, 4'hF);
    chk4("rst_vs_accept key_flag", key_flag, 4'h0);
    rst = 1'b0;
    wait_flag(0, 30, cyc);
    chk_int("post_rst accept latency", cyc, 10);
    chk4("post_rst key_value", key_value, 4'hE);
    key_in = 4'b1111;
    wait_flag(0, 30, cyc);
    chk_int("release latency", cyc, 10);
    chk4("release key_value", key_value, 4'hF);
    step();
    chk4("release flag drop", key_flag, 4'h0);

    // Staggered presses on keys 3 and 2 accept independently.
    first3 = -1;
    first2 = -1;
    both   = 0;
    key_in = 4'b0111;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 3) key_in = 4'b0011;
      if (key_flag[3] === 1'b1 && first3 < 0) first3 = c;
      if (key_flag[2] === 1'b1 && first2 < 0) first2 = c;
      if (key_flag[3] === 1'b1 && key_flag[2] === 1'b1) both++;
    end
    chk_int("stagger key3 latency", first3, 10);
    chk_int("stagger key2 latency", first2, 13);
    chk_int("stagger overlap", both, 0);
    chk4("stagger key_value", key_value, 4'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
